// File: rtl/dpram_copier.sv
// Byte-serial block copy engine driving one port of a 256-byte registered dual-port RAM.
// Optional fill mode (constant write, no reads) is enabled by defining COPIER_FILL_EN.
module dpram_copier (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] src_addr,
    input  logic [7:0] dst_addr,
    input  logic [7:0] len,
    output logic       busy,
    output logic       done,
    output logic [7:0] ram_addr,
    output logic [7:0] ram_wdata,
    output logic       ram_we,
    input  logic [7:0] ram_rdata
`ifdef COPIER_FILL_EN
    ,
    input  logic       fill,
    input  logic [7:0] fill_data
`endif
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD   = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_WR   = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0] state;
    logic [7:0] src;
    logic [7:0] dst;
    logic [7:0] cnt;

`ifdef COPIER_FILL_EN
    logic       fill_mode;
    logic       fill_req;
    logic [7:0] fill_byte;
    assign fill_req  = fill;
    assign fill_byte = fill_data;
`else
    localparam logic       fill_mode = 1'b0;
    localparam logic       fill_req  = 1'b0;
    localparam logic [7:0] fill_byte = 8'h00;
`endif

    // NOTE: non-blocking assignments so every register sees the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            ram_addr  <= 8'h00;
            ram_wdata <= 8'h00;
            ram_we    <= 1'b0;
            src       <= 8'h00;
            dst       <= 8'h00;
            cnt       <= 8'h00;
`ifdef COPIER_FILL_EN
            fill_mode <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (len == 8'd0) begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            src <= src_addr;
                            dst <= dst_addr;
                            cnt <= len;
`ifdef COPIER_FILL_EN
                            fill_mode <= fill_req;
`endif
                            if (fill_req) begin
                                // Fill skips the read phase; wdata stays constant for the whole run.
                                ram_addr  <= dst_addr;
                                ram_wdata <= fill_byte;
                                ram_we    <= 1'b1;
                                state     <= S_WR;
                            end else begin
                                ram_addr <= src_addr;
                                ram_we   <= 1'b0;
                                state    <= S_RD;
                            end
                        end
                    end
                end
                S_RD: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    ram_addr  <= dst;
                    ram_wdata <= ram_rdata;
                    ram_we    <= 1'b1;
                    state     <= S_WR;
                end
                S_WR: begin
                    src <= src + 8'd1;
                    dst <= dst + 8'd1;
                    cnt <= cnt - 8'd1;
                    if (cnt == 8'd1) begin
                        ram_we <= 1'b0;
                        done   <= 1'b1;
                        state  <= S_DONE;
                    end else if (fill_mode) begin
                        ram_addr <= dst + 8'd1;
                        ram_we   <= 1'b1;
                        state    <= S_WR;
                    end else begin
                        ram_addr <= src + 8'd1;
                        ram_we   <= 1'b0;
                        state    <= S_RD;
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy   <= 1'b0;
                    ram_we <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dpram_copier.sv
// Self-checking bench for dpram_copier: behavioural registered dual-port RAM, table-driven
// transfers plus hand-written reset-abort and start-while-busy sequences.
module tb_dpram_copier;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] src_addr;
    logic [7:0] dst_addr;
    logic [7:0] len;
    logic       busy;
    logic       done;
    logic [7:0] ram_addr;
    logic [7:0] ram_wdata;
    logic       ram_we;
    logic [7:0] ram_rdata;
`ifdef COPIER_FILL_EN
    logic       fill;
    logic [7:0] fill_data;
`endif

    // Port B of the RAM is used by the bench only to preload bytes.
    logic [7:0] mem [256];
    logic       b_we;
    logic [7:0] b_addr;
    logic [7:0] b_wdata;

    int checks;
    int failures;

    dpram_copier dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .src_addr  (src_addr),
        .dst_addr  (dst_addr),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_we    (ram_we),
        .ram_rdata (ram_rdata)
`ifdef COPIER_FILL_EN
        ,
        .fill      (fill),
        .fill_data (fill_data)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Port B is written last so it wins a same-address collision.
    always @(posedge clk) begin
        ram_rdata <= mem[ram_addr];
        if (ram_we) mem[ram_addr] <= ram_wdata;
        if (b_we)   mem[b_addr]   <= b_wdata;
    end

    typedef struct {
        logic [7:0]  src;
        logic [7:0]  dst;
        logic [7:0]  len;
        logic        fill;
        logic [7:0]  fdata;
        logic [31:0] pre;       // source bytes, byte 0 in [7:0]
        logic [31:0] exp;       // expected destination bytes, byte 0 in [7:0]
        int          done_edge; // edges after the accepting edge until done is seen
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Tasks start and end #1 after a rising edge.
    task automatic poke(input logic [7:0] a, input logic [7:0] d);
        b_we    = 1'b1;
        b_addr  = a;
        b_wdata = d;
        @(posedge clk); #1;
        b_we    = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic issue(input logic [7:0] s, input logic [7:0] d, input logic [7:0] n,
                         input logic f, input logic [7:0] fd);
        src_addr = s;
        dst_addr = d;
        len      = n;
`ifdef COPIER_FILL_EN
        fill      = f;
        fill_data = fd;
`else
        if (f) $display("note: fill vector issued without fill support (fd=%0h)", fd);
`endif
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int          k;
        int          seen;
        int          we_cnt;
        logic [7:0]  a;
        string       tag;
        tag = $sformatf("v%0d", idx);
        for (int i = 0; i < int'(v.len); i++) poke(v.dst + 8'(i), 8'hC3);
        poke(v.dst + v.len, 8'hC3);
        for (int i = 0; i < int'(v.len) && i < 4; i++) poke(v.src + 8'(i), v.pre[8*i +: 8]);
        issue(v.src, v.dst, v.len, v.fill, v.fdata);
        check({tag, "_busy_after_start"}, 32'(busy), 32'd1);
        k = 0; seen = -1; we_cnt = 0;
        while (k < 100) begin
            if (ram_we) we_cnt++;
            if (done) begin
                seen = k;
                break;
            end
            tick();
            k++;
        end
        check({tag, "_done_edge"}, 32'(seen), 32'(v.done_edge));
        check({tag, "_we_cycles"}, 32'(we_cnt), 32'(v.len));
        tick();
        check({tag, "_done_single"}, 32'(done), 32'd0);
        check({tag, "_busy_cleared"}, 32'(busy), 32'd0);
        for (int i = 0; i < int'(v.len) && i < 4; i++) begin
            a = v.dst + 8'(i);
            check($sformatf("%s_mem%02h", tag, a), 32'(mem[a]), 32'(v.exp[8*i +: 8]));
        end
        a = v.dst + v.len;
        check({tag, "_guard"}, 32'(mem[a]), 32'hC3);
    endtask

    initial begin
        int seen_done;
        checks = 0; failures = 0;
        rst = 1'b1; start = 1'b0; b_we = 1'b0; b_addr = 8'h00; b_wdata = 8'h00;
        src_addr = 8'h00; dst_addr = 8'h00; len = 8'h00;
`ifdef COPIER_FILL_EN
        fill = 1'b0; fill_data = 8'h00;
`endif
        repeat (2) tick();
        check("rst_busy",  32'(busy),      32'd0);
        check("rst_done",  32'(done),      32'd0);
        check("rst_we",    32'(ram_we),    32'd0);
        check("rst_addr",  32'(ram_addr),  32'd0);
        check("rst_wdata", 32'(ram_wdata), 32'd0);
        rst = 1'b0;
        tick();

        //                 src    dst    len   fill  fdata  pre            exp            edge
        vecs.push_back('{8'h10, 8'h80, 8'd4, 1'b0, 8'h00, 32'hA3A2A1A0, 32'hA3A2A1A0, 12});
        vecs.push_back('{8'h60, 8'h70, 8'd0, 1'b0, 8'h00, 32'h00000000, 32'h00000000, 0});
        vecs.push_back('{8'hFE, 8'h01, 8'd3, 1'b0, 8'h00, 32'h00332211, 32'h00332211, 9});
        vecs.push_back('{8'h20, 8'h22, 8'd4, 1'b0, 8'h00, 32'h00006655, 32'h66556655, 12});
        vecs.push_back('{8'h05, 8'h06, 8'd1, 1'b0, 8'h00, 32'h0000005C, 32'h0000005C, 3});
`ifdef COPIER_FILL_EN
        vecs.push_back('{8'h00, 8'h40, 8'd3, 1'b1, 8'hEE, 32'h00000000, 32'h00EEEEEE, 3});
`endif
        foreach (vecs[i]) run_vec(i, vecs[i]);

        // Reset during WAIT of byte 2: only byte 1 may land, no done pulse.
        poke(8'h30, 8'h11); poke(8'h31, 8'h22); poke(8'h32, 8'h33); poke(8'h33, 8'h44);
        for (int i = 0; i < 4; i++) poke(8'h90 + 8'(i), 8'hC3);
        issue(8'h30, 8'h90, 8'd4, 1'b0, 8'h00);
        repeat (4) tick();
        rst = 1'b1;
        tick();
        check("abort_busy", 32'(busy),   32'd0);
        check("abort_we",   32'(ram_we), 32'd0);
        check("abort_done", 32'(done),   32'd0);
        rst = 1'b0;
        seen_done = 0;
        for (int i = 0; i < 20; i++) begin
            if (done) seen_done = 1;
            tick();
        end
        check("abort_no_done", 32'(seen_done), 32'd0);
        check("abort_mem90",   32'(mem[8'h90]), 32'h11);
        check("abort_mem91",   32'(mem[8'h91]), 32'hC3);
        check("abort_mem93",   32'(mem[8'h93]), 32'hC3);

        // start while busy and start during DONE are both ignored.
        poke(8'h50, 8'h77); poke(8'h51, 8'h88);
        poke(8'hA0, 8'hC3); poke(8'hA1, 8'hC3); poke(8'hA2, 8'hC3);
        issue(8'h50, 8'hA0, 8'd2, 1'b0, 8'h00);
        tick();
        issue(8'h51, 8'hA2, 8'd1, 1'b0, 8'h00);
        seen_done = -1;
        for (int k = 2; k < 100; k++) begin
            if (done) begin
                seen_done = k;
                break;
            end
            tick();
        end
        check("busy_ign_done_edge", 32'(seen_done), 32'd6);
        start = 1'b1; src_addr = 8'h51; dst_addr = 8'hA2; len = 8'd1;
        tick();
        start = 1'b0;
        check("done_ign_busy", 32'(busy), 32'd0);
        check("done_ign_done", 32'(done), 32'd0);
        repeat (6) tick();
        check("busy_ign_memA0", 32'(mem[8'hA0]), 32'h77);
        check("busy_ign_memA1", 32'(mem[8'hA1]), 32'h88);
        check("busy_ign_memA2", 32'(mem[8'hA2]), 32'hC3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
